// File: rtl/snn_weight_dumper.sv
// snn_weight_dumper
//   Reads a window of the SNN synaptic weight RAM through its combinational
//   readback port and streams every weight, tagged with its address, on a
//   valid/ready channel. An optional final beat carries the 16-bit wrapping
//   sum of all streamed weights.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, abort      dump request (IDLE only) / terminate an active dump
//   base, len         first word address and word count, latched on start
//   rb_addr, rb_data  weight RAM readback address and same-cycle data
//   m_valid, m_ready  stream handshake
//   m_data, m_addr    weight (or checksum) and its address (0 on sum beat)
//   m_is_sum, m_last  checksum beat flag, final beat flag
//   busy, done        dump in progress, one-cycle completion pulse
module snn_weight_dumper #(
  parameter int F        = 48,
  parameter int N        = 96,
  parameter int AW       = $clog2(F*N),
  parameter int EMIT_SUM = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AW-1:0]        base,
  input  logic [AW:0]          len,
  output logic [AW-1:0]        rb_addr,
  input  logic signed [15:0]   rb_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [15:0]   m_data,
  output logic [AW-1:0]        m_addr,
  output logic                 m_is_sum,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam int          TOTAL   = F * N;
  localparam logic [AW:0] TOTAL_W = TOTAL[AW:0];
  localparam logic [AW:0] ONE_L   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, SUM, FIN} state_t;

  state_t              state, state_n;
  logic [AW-1:0]       rb_addr_n;
  logic [AW:0]         rem, rem_n;
  logic signed [15:0]  sum, sum_n;
  logic signed [15:0]  m_data_n;
  logic [AW-1:0]       m_addr_n;
  logic                m_valid_n, m_is_sum_n, m_last_n, busy_n, done_n;
  logic                free;

  // Words actually readable from base: nothing past the end of the RAM.
  function automatic logic [AW:0] clamp_len(input logic [AW-1:0] b,
                                            input logic [AW:0]   l);
    logic [AW:0] avail;
    if ({1'b0, b} >= TOTAL_W) return '0;
    avail = TOTAL_W - {1'b0, b};
    return (l < avail) ? l : avail;
  endfunction

  // Checksum accumulates modulo 2^16; overflow is intentional.
  function automatic logic signed [15:0] wrap_add(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
    return a + b;
  endfunction

  // Output register may take a new beat when empty or being drained.
  assign free = !m_valid || m_ready;

  always_comb begin
    state_n    = state;
    rb_addr_n  = rb_addr;
    rem_n      = rem;
    sum_n      = sum;
    m_valid_n  = m_valid;
    m_data_n   = m_data;
    m_addr_n   = m_addr;
    m_is_sum_n = m_is_sum;
    m_last_n   = m_last;
    busy_n     = busy;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          rb_addr_n  = base;
          rem_n      = clamp_len(base, len);
          sum_n      = '0;
          busy_n     = 1'b1;
          m_is_sum_n = 1'b0;
          m_last_n   = 1'b0;
          if (clamp_len(base, len) != '0) state_n = RUN;
          else if (EMIT_SUM != 0)         state_n = SUM;
          else                            state_n = FIN;
        end
      end
      RUN: begin
        if (abort) begin
          m_valid_n  = 1'b0;
          m_last_n   = 1'b0;
          m_is_sum_n = 1'b0;
          busy_n     = 1'b0;
          state_n    = IDLE;
        end else if (free) begin
          if (rem != '0) begin
            m_data_n   = rb_data;
            m_addr_n   = rb_addr;
            m_valid_n  = 1'b1;
            m_is_sum_n = 1'b0;
            m_last_n   = (rem == ONE_L) && (EMIT_SUM == 0);
            sum_n      = wrap_add(sum, rb_data);
            rb_addr_n  = rb_addr + ONE_A;
            rem_n      = rem - ONE_L;
          end else begin
            m_valid_n = 1'b0;
            m_last_n  = 1'b0;
            state_n   = (EMIT_SUM != 0) ? SUM : FIN;
          end
        end
      end
      SUM: begin
        if (abort) begin
          m_valid_n  = 1'b0;
          m_last_n   = 1'b0;
          m_is_sum_n = 1'b0;
          busy_n     = 1'b0;
          state_n    = IDLE;
        end else if (!m_valid) begin
          m_valid_n  = 1'b1;
          m_data_n   = sum;
          m_addr_n   = '0;
          m_is_sum_n = 1'b1;
          m_last_n   = 1'b1;
        end else if (m_ready) begin
          m_valid_n = 1'b0;
          state_n   = FIN;
        end
      end
      FIN: begin
        done_n     = 1'b1;
        busy_n     = 1'b0;
        m_valid_n  = 1'b0;
        m_is_sum_n = 1'b0;
        m_last_n   = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rb_addr  <= '0;
      rem      <= '0;
      sum      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_addr   <= '0;
      m_is_sum <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rb_addr  <= rb_addr_n;
      rem      <= rem_n;
      sum      <= sum_n;
      m_valid  <= m_valid_n;
      m_data   <= m_data_n;
      m_addr   <= m_addr_n;
      m_is_sum <= m_is_sum_n;
      m_last   <= m_last_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_snn_weight_dumper.sv
// tb_snn_weight_dumper
//   Directed bench for snn_weight_dumper. Two instances share stimulus: one
//   with the checksum beat (EMIT_SUM=1) and one without (EMIT_SUM=0). The
//   weight RAM is modelled as weight[i] = i - 2304.
module tb_snn_weight_dumper;
  localparam int AW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, m_ready;
  logic [AW-1:0] base;
  logic [AW:0]   len;

  logic [AW-1:0]      rb_addr, m_addr;
  logic signed [15:0] rb_data;
  logic [15:0]        m_data;
  logic               m_valid, m_is_sum, m_last, busy, done;

  logic [AW-1:0]      e0_rb_addr, e0_addr;
  logic signed [15:0] e0_rb_data;
  logic [15:0]        e0_data;
  logic               e0_valid, e0_is_sum, e0_last, e0_busy, e0_done;

  assign rb_data    = $signed({3'b000, rb_addr})    - 16'sd2304;
  assign e0_rb_data = $signed({3'b000, e0_rb_addr}) - 16'sd2304;

  snn_weight_dumper #(.F(48), .N(96), .AW(AW), .EMIT_SUM(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base), .len(len),
    .rb_addr(rb_addr), .rb_data(rb_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_addr(m_addr), .m_is_sum(m_is_sum), .m_last(m_last),
    .busy(busy), .done(done));

  snn_weight_dumper #(.F(48), .N(96), .AW(AW), .EMIT_SUM(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base), .len(len),
    .rb_addr(e0_rb_addr), .rb_data(e0_rb_data), .m_valid(e0_valid), .m_ready(m_ready),
    .m_data(e0_data), .m_addr(e0_addr), .m_is_sum(e0_is_sum), .m_last(e0_last),
    .busy(e0_busy), .done(e0_done));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind: 0 plain, 1 extra start while busy, 2 abort, 3 reset; poke fires
  // in the cycle of handshake number poke_at.
  task automatic dump(input string tag, input logic [AW-1:0] b, input logic [AW:0] l,
                      input int rpct, input int exp_data, input logic [15:0] exp_sum,
                      input int poke_at, input int kind);
    int hs = 0, errs = 0, stall_errs = 0, cyc = 0;
    bit seen_done = 0, prev_stall = 0, stop = 0;
    logic [15:0]   pd;
    logic [AW-1:0] pa, ea;
    logic [15:0]   ed;
    logic          d;
    @(negedge clk);
    base = b; len = l; start = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    while (cyc < 20000) begin
      start = 1'b0;
      if (done) begin seen_done = 1; break; end
      m_ready = ($urandom_range(99) < rpct);
      if (prev_stall && (m_data !== pd || m_addr !== pa)) stall_errs++;
      prev_stall = m_valid && !m_ready;
      pd = m_data; pa = m_addr;
      if (m_valid && m_ready) begin
        if (hs < exp_data) begin
          ea = b + AW'(hs);
          ed = {3'b000, ea} - 16'd2304;
          if (m_addr !== ea || m_data !== ed || m_is_sum !== 1'b0 || m_last !== 1'b0) errs++;
        end else if (hs == exp_data) begin
          if (m_addr !== '0 || m_data !== exp_sum || m_is_sum !== 1'b1 || m_last !== 1'b1) errs++;
        end else begin
          errs++;
        end
        hs++;
        if (hs == poke_at) begin
          case (kind)
            1: begin start = 1'b1; base = '0; len = 14'd100; end
            2: begin abort = 1'b1; stop = 1; end
            3: begin rst = 1'b1; stop = 1; end
            default: ;
          endcase
        end
      end
      @(negedge clk);
      cyc++;
      if (stop) break;
    end
    if (kind == 2) begin
      abort = 1'b0;
      check({tag, "_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_beats"}, hs, poke_at);
      d = 1'b0;
      repeat (5) begin @(negedge clk); d = d | done; end
      check({tag, "_nodone"}, 32'(d), 32'd0);
    end else if (kind == 3) begin
      check({tag, "_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_data"}, 32'(m_data), 32'd0);
      check({tag, "_addr"}, 32'(m_addr), 32'd0);
      check({tag, "_rbaddr"}, 32'(rb_addr), 32'd0);
      check({tag, "_last"}, 32'(m_last), 32'd0);
      rst = 1'b0;
      d = 1'b0;
      repeat (4) begin @(negedge clk); d = d | done | m_valid; end
      check({tag, "_quiet"}, 32'(d), 32'd0);
    end else begin
      check({tag, "_done"}, 32'(seen_done), 32'd1);
      check({tag, "_beats"}, hs, exp_data + 1);
      check({tag, "_beat_errs"}, errs, 0);
      check({tag, "_stall_errs"}, stall_errs, 0);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; base = '0; len = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rbaddr", 32'(rb_addr), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    rst = 1'b0;

    dump("full", 13'd0, 14'd4608, 100, 4608, 16'hF700, -1, 0);
    dump("rand", 13'd0, 14'd4608, 50, 4608, 16'hF700, -1, 0);
    dump("clamp", 13'd4600, 14'd20, 100, 8, 16'h47DC, -1, 0);
    dump("oob", 13'd5000, 14'd20, 100, 0, 16'h0000, -1, 0);
    dump("abort", 13'd0, 14'd4608, 100, 4608, 16'hF700, 100, 2);
    dump("post_abort", 13'd0, 14'd4, 100, 4, 16'hDC06, -1, 0);
    dump("rst_mid", 13'd0, 14'd4608, 100, 4608, 16'hF700, 50, 3);
    dump("busy_start", 13'd4600, 14'd20, 50, 8, 16'h47DC, 4, 1);

    // Zero-length dump without checksum beat.
    @(negedge clk);
    m_ready = 1'b1; base = '0; len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("z_busy_on", 32'(e0_busy), 32'd1);
    check("z_done_early", 32'(e0_done), 32'd0);
    check("z_valid", 32'(e0_valid), 32'd0);
    @(negedge clk);
    check("z_done", 32'(e0_done), 32'd1);
    check("z_busy_off", 32'(e0_busy), 32'd0);
    check("z_valid2", 32'(e0_valid), 32'd0);
    @(negedge clk);
    check("z_done_pulse", 32'(e0_done), 32'd0);
    repeat (6) @(negedge clk);

    // Two-word dump without checksum beat: last flag on the final data beat.
    base = 13'd10; len = 14'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("l_valid0", 32'(e0_valid), 32'd0);
    @(negedge clk);
    check("l_b0_valid", 32'(e0_valid), 32'd1);
    check("l_b0_addr", 32'(e0_addr), 32'd10);
    check("l_b0_data", 32'(e0_data), 32'hF70A);
    check("l_b0_last", 32'(e0_last), 32'd0);
    @(negedge clk);
    check("l_b1_addr", 32'(e0_addr), 32'd11);
    check("l_b1_data", 32'(e0_data), 32'hF70B);
    check("l_b1_last", 32'(e0_last), 32'd1);
    @(negedge clk);
    check("l_valid_end", 32'(e0_valid), 32'd0);
    @(negedge clk);
    check("l_done", 32'(e0_done), 32'd1);
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
